// File: rtl/fpu_writeback_queue.sv
// ---------------------------------------------------------------------------
// fpu_writeback_queue
//
// Merges results from two FPU producers into one in-order FIFO that feeds the
// float register file's single write port. Producer A is the pipelined
// fadd/fmul unit and producer B is the iterative fdiv/fsqrt/fcvt unit. The
// module also holds the per-register busy scoreboard that decode uses for its
// RAW/WAW hazard checks.
//
// Ports
//   clk, rstn          clock (posedge) and asynchronous active-low reset
//   clken              global stall; when low, all state is frozen
//   a_valid/a_ready    producer A handshake; a_rd/a_data are its result
//   b_valid/b_ready    producer B handshake; b_rd/b_data are its result
//   rsv_valid/rsv_rd   decode reserves a destination register (sets busy)
//   q_rs1..q_rs3       hazard query registers
//   busy1..busy3       query results (pending write not yet visible)
//   rdi/write_data     register file write address and data (FIFO head)
//   reg_write          register file write enable (FIFO not empty)
//   occupancy          number of FIFO entries held
//   err                sticky protocol-error flag
// ---------------------------------------------------------------------------
module fpu_writeback_queue #(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 32,
   parameter int CNT_W  = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              clken,
   input  logic              a_valid,
   output logic              a_ready,
   input  logic [4:0]        a_rd,
   input  logic [DATA_W-1:0] a_data,
   input  logic              b_valid,
   output logic              b_ready,
   input  logic [4:0]        b_rd,
   input  logic [DATA_W-1:0] b_data,
   input  logic              rsv_valid,
   input  logic [4:0]        rsv_rd,
   input  logic [4:0]        q_rs1,
   input  logic [4:0]        q_rs2,
   input  logic [4:0]        q_rs3,
   output logic              busy1,
   output logic              busy2,
   output logic              busy3,
   output logic [4:0]        rdi,
   output logic [DATA_W-1:0] write_data,
   output logic              reg_write,
   output logic [CNT_W-1:0]  occupancy,
   output logic              err
);

   localparam int              PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CNT_W:0]  C_DEPTH = (CNT_W + 1)'(DEPTH);

   // Entry storage carries no reset: an empty queue never exposes it.
   logic [4:0]        r_rd_q   [DEPTH];
   logic [DATA_W-1:0] r_data_q [DEPTH];

   logic [PTR_W-1:0]  r_wptr;
   logic [PTR_W-1:0]  r_rptr;
   logic [CNT_W-1:0]  r_occ;
   logic [31:0]       r_busy;
   logic              r_err;

   logic [CNT_W:0]    w_occ_ext;
   logic [CNT_W:0]    w_b_lim;
   logic              w_a_push;
   logic              w_b_push;
   logic              w_pop;
   logic              w_rsv;
   logic [PTR_W-1:0]  w_b_slot;
   logic [31:0]       w_busy_nxt;
   logic              w_err_a;
   logic              w_err_b;
   logic              w_err_rsv;

   // A pending write is hidden from the query when it is being written this
   // cycle, because the register file forwards the write-port value.
   function automatic logic f_busy_q(input logic [31:0] busy_vec,
                                     input logic [4:0]  q,
                                     input logic        wr_en,
                                     input logic [4:0]  wr_rd);
      return busy_vec[q] & ~(wr_en & (wr_rd == q));
   endfunction

   // Ready is derived from stored occupancy only; a same-cycle pop is not
   // credited, which keeps ready free of any path through the pop logic.
   assign w_occ_ext = {1'b0, r_occ};
   assign w_b_lim   = C_DEPTH - {{CNT_W{1'b0}}, a_valid};
   assign a_ready   = w_occ_ext < C_DEPTH;
   assign b_ready   = w_occ_ext < w_b_lim;

   assign w_a_push  = a_valid & a_ready & clken;
   assign w_b_push  = b_valid & b_ready & clken;
   assign w_rsv     = rsv_valid & clken;

   // B lands behind A when both push in the same cycle.
   assign w_b_slot  = r_wptr + PTR_W'(w_a_push);

   assign reg_write  = (r_occ != '0);
   assign rdi        = reg_write ? r_rd_q[r_rptr]   : 5'd0;
   assign write_data = reg_write ? r_data_q[r_rptr] : '0;
   assign occupancy  = r_occ;
   assign err        = r_err;
   assign w_pop      = reg_write & clken;

   assign busy1 = f_busy_q(r_busy, q_rs1, reg_write, rdi);
   assign busy2 = f_busy_q(r_busy, q_rs2, reg_write, rdi);
   assign busy3 = f_busy_q(r_busy, q_rs3, reg_write, rdi);

   // Clear is applied before set so a same-cycle reserve of the retiring
   // register leaves it busy for the new owner.
   always_comb begin
      w_busy_nxt = r_busy;
      if (w_pop) w_busy_nxt[rdi]    = 1'b0;
      if (w_rsv) w_busy_nxt[rsv_rd] = 1'b1;
   end

   assign w_err_a   = w_a_push & ~r_busy[a_rd] & ~(w_rsv & (rsv_rd == a_rd));
   assign w_err_b   = w_b_push & ~r_busy[b_rd] & ~(w_rsv & (rsv_rd == b_rd));
   assign w_err_rsv = w_rsv & r_busy[rsv_rd] & ~(w_pop & (rdi == rsv_rd));

   // Stage boundary: entry storage write
   always_ff @(posedge clk) begin
      if (w_a_push) begin
         r_rd_q[r_wptr]   <= a_rd;
         r_data_q[r_wptr] <= a_data;
      end
      if (w_b_push) begin
         r_rd_q[w_b_slot]   <= b_rd;
         r_data_q[w_b_slot] <= b_data;
      end
   end

   // Stage boundary: pointers, occupancy, scoreboard and error flag
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_occ  <= '0;
         r_busy <= '0;
         r_err  <= 1'b0;
      end else if (clken) begin
         r_wptr <= r_wptr + PTR_W'(w_a_push) + PTR_W'(w_b_push);
         r_rptr <= r_rptr + PTR_W'(w_pop);
         r_occ  <= r_occ + CNT_W'(w_a_push) + CNT_W'(w_b_push) - CNT_W'(w_pop);
         r_busy <= w_busy_nxt;
         r_err  <= r_err | w_err_a | w_err_b | w_err_rsv;
      end
   end

endmodule
